axis_upsizer_2x: RTL
====================

AXIS_UPSIZER_2X -- requirements
Module: axis_upsizer_2x

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: input TDATA width in bits, a multiple of 8, at least 8.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the packet counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 ACLK  input  1  clock; all state changes on its rising edge.
REQ-005 ARESETN  input  1  asynchronous active-low reset.
REQ-006 in_TDATA  input  IN_WIDTH  sink data.
REQ-007 in_TKEEP  input  IN_WIDTH/8  sink byte-valid mask.
REQ-008 in_TLAST  input  1  sink last beat of packet.
REQ-009 in_TVALID  input  1  sink beat valid.
REQ-010 in_TREADY  output  1  sink ready.
REQ-011 out_TDATA  output  2*IN_WIDTH  source data.
REQ-012 out_TKEEP  output  IN_WIDTH/4  source byte-valid mask.
REQ-013 out_TLAST  output  1  source last beat of packet.
REQ-014 out_TVALID  output  1  source beat valid.
REQ-015 out_TREADY  input  1  source ready.
REQ-016 packets  output  CNT_WIDTH  number of output beats accepted with out_TLAST=1.

Function
REQ-017 SHALL define an input transfer as in_TVALID&&in_TREADY on a rising edge, and an output transfer as out_TVALID&&out_TREADY on a rising edge.
REQ-018 SHALL hold a half register (lo_data, lo_keep) and an output register (out_*) driven directly from flops, with state LOW (half register empty) or HIGH (half register holds the first beat of a pair).
REQ-019 SHALL drive in_TREADY = !out_TVALID || out_TREADY, combinationally, in both states.
REQ-020 On an input transfer in LOW with in_TLAST=0: SHALL load lo_data/lo_keep, go to HIGH, and leave the output register unchanged.
REQ-021 On an input transfer in LOW with in_TLAST=1: SHALL load out_TDATA={IN_WIDTH'0, in_TDATA}, out_TKEEP={zeros, in_TKEEP}, out_TLAST=1 and out_TVALID=1, and stay in LOW.
REQ-022 On an input transfer in HIGH: SHALL load out_TDATA={in_TDATA, lo_data}, out_TKEEP={in_TKEEP, lo_keep}, out_TLAST=in_TLAST and out_TVALID=1, then go to LOW.
REQ-023 Lower half = first-arrived beat (little-endian byte order); in_TKEEP is passed through unmodified, with no checking.
REQ-024 On an output transfer with no simultaneous load: SHALL clear out_TVALID next cycle, with out_TDATA, out_TKEEP and out_TLAST don't-care.
REQ-025 Simultaneous output transfer and load (REQ-021/022): the load wins and out_TVALID stays 1, so full throughput is one output beat per two input beats with no bubble.
REQ-026 While out_TVALID=1 and out_TREADY=0: out_TDATA, out_TKEEP and out_TLAST SHALL be held stable, and in_TREADY=0.
REQ-027 Latency: first output beat valid 1 cycle after the completing input transfer.
REQ-028 packets SHALL increment by 1 on each output transfer with out_TLAST=1 and wrap modulo 2^CNT_WIDTH; it is never cleared except by reset.
REQ-029 Odd-length packet: the final beat is emitted alone per REQ-021, upper TKEEP is all zeros, and the next packet starts in LOW.
REQ-030 A single-beat packet is handled per REQ-021 with no special case.

Reset
REQ-031 ARESETN=0 SHALL immediately force state=LOW, out_TVALID=0, out_TLAST=0, out_TDATA=0, out_TKEEP=0, lo_data=0, lo_keep=0 and packets=0.
REQ-032 Reset mid-packet SHALL discard any partial pair and pending output beat; after release, the first input beat is treated as the start of a new packet.
REQ-033 in_TREADY SHALL be 1 during and after reset (out_TVALID=0); upstream is expected to hold in_TVALID=0 while ARESETN=0.

Verification
REQ-034 Stream 4 beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on 4th, TKEEP=F), out_TREADY=1 -> 2 outputs 0x2222222211111111 (TKEEP=FF, TLAST=0) and 0x4444444433333333 (TKEEP=FF, TLAST=1); packets=1.
REQ-035 3-beat packet A, B, C, TLAST on C, C TKEEP=3 -> outputs {B,A} TKEEP=FF TLAST=0, then {0,C} TKEEP=03 TLAST=1; the next packet's first beat lands in the lower half.
REQ-036 out_TREADY=0 for 5 cycles with an output pending -> out_* stable, in_TREADY=0, no input lost; after release, the sequence matches the no-stall run.
REQ-037 Continuous in_TVALID=1 with out_TREADY=1 over 100 beats -> 50 output beats, no output bubble between consecutive pairs, every byte in order.
REQ-038 Assert ARESETN=0 while in HIGH with out_TVALID=1 -> out_TVALID=0 immediately and packets=0; after release, stream D, E with TLAST on E -> single output {E,D} TLAST=1.
REQ-039 CNT_WIDTH=4, send 17 single-beat packets -> packets wraps to 1.

Source files
------------

// File: rtl/axis_upsizer_2x.sv
// axis_upsizer_2x: packs pairs of AXI-Stream beats into one double-width beat, counting emitted packets
module axis_upsizer_2x #(
    parameter int IN_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [IN_WIDTH-1:0]     in_TDATA,
    input  logic [IN_WIDTH/8-1:0]   in_TKEEP,
    input  logic                    in_TLAST,
    input  logic                    in_TVALID,
    output logic                    in_TREADY,
    output logic [2*IN_WIDTH-1:0]   out_TDATA,
    output logic [IN_WIDTH/4-1:0]   out_TKEEP,
    output logic                    out_TLAST,
    output logic                    out_TVALID,
    input  logic                    out_TREADY,
    output logic [CNT_WIDTH-1:0]    packets
);
    localparam int KW = IN_WIDTH / 8;
    localparam logic [0:0] LOW  = 1'b0;
    localparam logic [0:0] HIGH = 1'b1;

    logic [0:0]          state;
    logic [IN_WIDTH-1:0] lo_data;
    logic [KW-1:0]       lo_keep;
    logic                in_xfer;
    logic                out_xfer;
    logic                load;

    assign in_TREADY = !out_TVALID || out_TREADY;
    assign in_xfer   = in_TVALID && in_TREADY;
    assign out_xfer  = out_TVALID && out_TREADY;
    assign load      = in_xfer && (state == HIGH || in_TLAST);

    // Pair assembly: first beat parks in the half register, second (or a lone last beat) fills the output register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= LOW;
            lo_data    <= '0;
            lo_keep    <= '0;
            out_TDATA  <= '0;
            out_TKEEP  <= '0;
            out_TLAST  <= 1'b0;
            out_TVALID <= 1'b0;
        end else begin
            if (in_xfer && state == LOW && !in_TLAST) begin
                lo_data <= in_TDATA;
                lo_keep <= in_TKEEP;
                state   <= HIGH;
            end else if (load) begin
                out_TDATA <= (state == HIGH) ? {in_TDATA, lo_data} : {{IN_WIDTH{1'b0}}, in_TDATA};
                out_TKEEP <= (state == HIGH) ? {in_TKEEP, lo_keep} : {{KW{1'b0}}, in_TKEEP};
                out_TLAST <= (state == HIGH) ? in_TLAST : 1'b1;
                state     <= LOW;
            end
            out_TVALID <= load ? 1'b1 : (out_xfer ? 1'b0 : out_TVALID);
        end
    end

    // Packet counter: one per accepted output beat carrying TLAST, wrapping naturally
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            packets <= '0;
        else if (out_xfer && out_TLAST)
            packets <= packets + CNT_WIDTH'(1);
    end
endmodule
